score_keeper: RTL and testbench

Match-state controller for Pong, directly upstream of the score digit generators. Consumes one-cycle goal pulses from the ball logic and the per-frame tick, and maintains both 3-bit player scores. Sequences the serve delay and game-over conditions, and emits the serve pulse, ball freeze and winner flags. Its `score_left`/`score_right` outputs drive the `score` inputs of the two digit generators.

---
 rtl/score_keeper_pkg.sv | 19 +
 rtl/score_keeper_frame_counter.sv | 28 ++
 rtl/score_keeper.sv | 146 ++++++++++++++
 tb/tb_score_keeper.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared types and defaults for the Pong match-state controller.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam int SCORE_W                = 3;
    localparam int DEF_WIN_SCORE          = 7;
    localparam int DEF_SERVE_DELAY_FRAMES = 60;
    localparam int DEF_BLINK_FRAMES       = 15;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/score_keeper_frame_counter.sv
// frame_counter: counts tick pulses up to LIMIT, clears synchronously,
// and flags the tick that completes the count (count wraps to 0 there).
module frame_counter #(
    parameter int LIMIT = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic done
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;
    logic         at_limit;

    assign at_limit = (count == W'(LIMIT - 1));
    assign done     = tick && !clr && at_limit;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (tick)
            count <= at_limit ? '0 : count + W'(1);
    end

endmodule

// File: rtl/score_keeper.sv
// Pong match-state controller: scores, serve delay, game over and winner flags.
// Optional winner-digit blink in OVER is enabled by defining SCORE_BLINK_EN.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int WIN_SCORE          = DEF_WIN_SCORE,
    parameter int SERVE_DELAY_FRAMES = DEF_SERVE_DELAY_FRAMES
`ifdef SCORE_BLINK_EN
    ,parameter int BLINK_FRAMES      = DEF_BLINK_FRAMES
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               goal_left,
    input  logic               goal_right,
    input  logic               new_game,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               ball_freeze,
    output logic               serve,
    output logic               serve_dir,
    output logic               game_over,
    output logic               winner,
    output logic               show_left,
    output logic               show_right
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_t             state;
    logic               serve_done;
    logic [SCORE_W-1:0] left_inc;
    logic [SCORE_W-1:0] right_inc;

    assign left_inc  = score_inc(score_left);
    assign right_inc = score_inc(score_right);

    // Only counts in PAUSE; a tick landing with new_game is dropped by the clear.
    frame_counter #(.LIMIT(SERVE_DELAY_FRAMES)) u_serve_delay (
        .clk  (clk),
        .rst  (rst),
        .clr  (new_game || state != ST_PAUSE),
        .tick (frame_tick && state == ST_PAUSE),
        .done (serve_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_PAUSE;
            score_left  <= '0;
            score_right <= '0;
            serve_dir   <= 1'b0;
            serve       <= 1'b0;
            ball_freeze <= 1'b1;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else if (new_game) begin
            state       <= ST_PAUSE;
            score_left  <= '0;
            score_right <= '0;
            serve       <= 1'b0;
            ball_freeze <= 1'b1;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            serve <= 1'b0;
            case (state)
                ST_PAUSE: begin
                    ball_freeze <= 1'b1;
                    if (serve_done) begin
                        serve       <= 1'b1;
                        ball_freeze <= 1'b0;
                        state       <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // Serve goes toward the player who just conceded.
                    if (goal_left && goal_right) begin
                        state       <= ST_PAUSE;
                        ball_freeze <= 1'b1;
                    end else if (goal_left) begin
                        score_right <= right_inc;
                        serve_dir   <= 1'b0;
                        ball_freeze <= 1'b1;
                        if (right_inc == WIN) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                        end else begin
                            state <= ST_PAUSE;
                        end
                    end else if (goal_right) begin
                        score_left  <= left_inc;
                        serve_dir   <= 1'b1;
                        ball_freeze <= 1'b1;
                        if (left_inc == WIN) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                        end else begin
                            state <= ST_PAUSE;
                        end
                    end
                end
                ST_OVER: begin
                    ball_freeze <= 1'b1;
                    game_over   <= 1'b1;
                end
                default: begin
                    state       <= ST_PAUSE;
                    ball_freeze <= 1'b1;
                end
            endcase
        end
    end

`ifdef SCORE_BLINK_EN
    logic blink_done;

    frame_counter #(.LIMIT(BLINK_FRAMES)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .clr  (new_game || state != ST_OVER),
        .tick (frame_tick && state == ST_OVER),
        .done (blink_done)
    );

    // Held high outside OVER so the blink always starts lit.
    always_ff @(posedge clk) begin
        if (rst || new_game || state != ST_OVER) begin
            show_left  <= 1'b1;
            show_right <= 1'b1;
        end else if (blink_done) begin
            if (winner)
                show_right <= ~show_right;
            else
                show_left  <= ~show_left;
        end
    end
`else
    assign show_left  = 1'b1;
    assign show_right = 1'b1;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: table of stimulus rows with expected
// outputs after the last cycle of each row, passed through a scoreboard queue.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       goal_left = 1'b0;
    logic       goal_right = 1'b0;
    logic       new_game = 1'b0;
    logic [2:0] score_left, score_right;
    logic       ball_freeze, serve, serve_dir, game_over, winner;
    logic       show_left, show_right;

    score_keeper dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .goal_left   (goal_left),
        .goal_right  (goal_right),
        .new_game    (new_game),
        .score_left  (score_left),
        .score_right (score_right),
        .ball_freeze (ball_freeze),
        .serve       (serve),
        .serve_dir   (serve_dir),
        .game_over   (game_over),
        .winner      (winner),
        .show_left   (show_left),
        .show_right  (show_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rs, ft, gl, gr, ng;
        int         rep;
        logic [2:0] sl, sr;
        logic       frz, srv, dir, ov, wn, shl, shr;
    } row_t;

    row_t tbl[$];
    row_t exp_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

`ifdef SCORE_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    function automatic row_t mk(string n, logic rs, logic ft, logic gl, logic gr, logic ng,
                                int rep, int e_sl, int e_sr, logic frz, logic srv,
                                logic dir, logic ov, logic wn);
        row_t r;
        r.name = n; r.rs = rs; r.ft = ft; r.gl = gl; r.gr = gr; r.ng = ng; r.rep = rep;
        r.sl = 3'(e_sl); r.sr = 3'(e_sr);
        r.frz = frz; r.srv = srv; r.dir = dir; r.ov = ov; r.wn = wn;
        r.shl = 1'b1; r.shr = 1'b1;
        return r;
    endfunction

    task automatic chk(string nm, string f, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s.%s actual=%0d expected=%0d", nm, f, act, exp);
        end
    endtask

    task automatic run_row(row_t r);
        row_t e;
        for (int k = 0; k < r.rep; k++) begin
            @(negedge clk);
            rst = r.rs; frame_tick = r.ft; goal_left = r.gl;
            goal_right = r.gr; new_game = r.ng;
            exp_q.push_back(r);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if (k == e.rep - 1) begin
                chk(e.name, "score_left",  int'(score_left),  int'(e.sl));
                chk(e.name, "score_right", int'(score_right), int'(e.sr));
                chk(e.name, "ball_freeze", int'(ball_freeze), int'(e.frz));
                chk(e.name, "serve",       int'(serve),       int'(e.srv));
                chk(e.name, "serve_dir",   int'(serve_dir),   int'(e.dir));
                chk(e.name, "game_over",   int'(game_over),   int'(e.ov));
                if (e.ov || e.rs)
                    chk(e.name, "winner", int'(winner), int'(e.wn));
                chk(e.name, "show_left",   int'(show_left),   int'(e.shl));
                chk(e.name, "show_right",  int'(show_right),  int'(e.shr));
            end else begin
                chk(e.name, "serve_mid", int'(serve), 0);
            end
        end
        @(negedge clk);
        rst = 0; frame_tick = 0; goal_left = 0; goal_right = 0; new_game = 0;
    endtask

    initial begin
        row_t r;
        tbl.push_back(mk("reset",         1,0,0,0,0, 2,  0,0, 1,0,0,0,0));
        tbl.push_back(mk("ticks59",       0,1,0,0,0, 59, 0,0, 1,0,0,0,0));
        tbl.push_back(mk("goal_in_pause", 0,0,0,1,0, 1,  0,0, 1,0,0,0,0));
        tbl.push_back(mk("tick60",        0,1,0,0,0, 1,  0,0, 0,1,0,0,0));
        tbl.push_back(mk("play_idle",     0,0,0,0,0, 3,  0,0, 0,0,0,0,0));
        tbl.push_back(mk("goal_right",    0,0,0,1,0, 1,  1,0, 1,0,1,0,0));
        tbl.push_back(mk("delay59",       0,1,0,0,0, 59, 1,0, 1,0,1,0,0));
        tbl.push_back(mk("serve2",        0,1,0,0,0, 1,  1,0, 0,1,1,0,0));
        tbl.push_back(mk("both_goals",    0,0,1,1,0, 1,  1,0, 1,0,1,0,0));
        tbl.push_back(mk("serve3",        0,1,0,0,0, 60, 1,0, 0,1,1,0,0));
        for (int i = 1; i < 7; i++) begin
            tbl.push_back(mk("goal_left", 0,0,1,0,0, 1,  1,i, 1,0,0,0,0));
            tbl.push_back(mk("serve_n",   0,1,0,0,0, 60, 1,i, 0,1,0,0,0));
        end
        tbl.push_back(mk("goal_win",      0,0,1,0,0, 1,  1,7, 1,0,0,1,1));
        tbl.push_back(mk("goal_in_over",  0,0,1,0,0, 3,  1,7, 1,0,0,1,1));
        tbl.push_back(mk("ticks_in_over", 0,1,0,0,0, 5,  1,7, 1,0,0,1,1));
        tbl.push_back(mk("new_game_goal", 0,0,1,0,1, 1,  0,0, 1,0,0,0,0));
        tbl.push_back(mk("ng_delay59",    0,1,0,0,0, 59, 0,0, 1,0,0,0,0));
        tbl.push_back(mk("ng_tick60",     0,1,0,0,0, 1,  0,0, 0,1,0,0,0));
        tbl.push_back(mk("goal_right2",   0,0,0,1,0, 1,  1,0, 1,0,1,0,0));
        tbl.push_back(mk("ticks30",       0,1,0,0,0, 30, 1,0, 1,0,1,0,0));
        tbl.push_back(mk("ng_with_tick",  0,1,0,0,1, 1,  0,0, 1,0,1,0,0));
        tbl.push_back(mk("after_ng59",    0,1,0,0,0, 59, 0,0, 1,0,1,0,0));
        tbl.push_back(mk("after_ng60",    0,1,0,0,0, 1,  0,0, 0,1,1,0,0));
        tbl.push_back(mk("goal_right3",   0,0,0,1,0, 1,  1,0, 1,0,1,0,0));
        tbl.push_back(mk("ticks20",       0,1,0,0,0, 20, 1,0, 1,0,1,0,0));
        tbl.push_back(mk("rst_mid_delay", 1,1,0,0,0, 1,  0,0, 1,0,0,0,0));
        tbl.push_back(mk("rst_delay59",   0,1,0,0,0, 59, 0,0, 1,0,0,0,0));
        tbl.push_back(mk("rst_tick60",    0,1,0,0,0, 1,  0,0, 0,1,0,0,0));

        foreach (tbl[i]) run_row(tbl[i]);

        // Right player wins again, then exercise the winner-digit blink.
        for (int i = 1; i <= 7; i++) begin
            run_row(mk("win_goal", 0,0,1,0,0, 1, 0,i, 1,0,0,(i == 7),(i == 7)));
            if (i < 7)
                run_row(mk("win_serve", 0,1,0,0,0, 60, 0,i, 0,1,0,0,0));
        end
        r = mk("blink14", 0,1,0,0,0, 14, 0,7, 1,0,0,1,1);
        run_row(r);
        r = mk("blink15", 0,1,0,0,0, 1, 0,7, 1,0,0,1,1);
        r.shr = !BLINK;
        run_row(r);
        r = mk("blink30", 0,1,0,0,0, 15, 0,7, 1,0,0,1,1);
        run_row(r);
        r = mk("blink45", 0,1,0,0,0, 15, 0,7, 1,0,0,1,1);
        r.shr = !BLINK;
        run_row(r);
        run_row(mk("rst_in_over", 1,0,0,0,0, 1, 0,0, 1,0,0,0,0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
